// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: sequences instruction-memory requests and applies branch/jump redirects.
// Redirect targets win over stall and memory back-pressure; wrong-path fetches are dropped.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       Jump_sel,
   input  logic [31:0]      Branch_pc4,
   input  logic [31:0]      Imm_sext,
   input  logic [25:0]      Target,
   input  logic [31:0]      RS,
   input  logic             Stall,
   input  logic             Imem_ready,
   output logic             Imem_req,
   output logic [31:0]      Imem_addr,
   output logic             Fetch_valid,
   output logic [31:0]      Fetch_pc,
   output logic [31:0]      Fetch_pc4,
   output logic             Flush,
   output logic             Addr_err,
   output logic [CNT_W-1:0] Redirect_cnt
);

   typedef enum logic [0:0] {StBoot, StFetch} state_e;

   state_e           state_q;
   logic [31:0]      pc_q;
   logic [31:0]      pc_d;
   logic [31:0]      target;
   logic             fetch_valid_q;
   logic [31:0]      fetch_pc_q;
   logic             addr_err_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_fetch;
   logic             redirect;
   logic             accept;
   logic             rs_misaligned;
   logic             unused_imm_hi;

   assign unused_imm_hi = ^Imm_sext[31:30];

   assign in_fetch      = (state_q == StFetch);
   assign redirect      = in_fetch && (Jump_sel != 2'b00);
   assign accept        = Imem_req && Imem_ready;
   assign rs_misaligned = (Jump_sel == 2'b11) && (RS[1:0] != 2'b00);

   always_comb begin
      target = Branch_pc4;
      case (Jump_sel)
         2'b01:   target = Branch_pc4 + {Imm_sext[29:0], 2'b00};
         2'b10:   target = {Branch_pc4[31:28], Target, 2'b00};
         2'b11:   target = {RS[31:2], 2'b00};
         default: target = Branch_pc4;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = target;
      end else if (accept) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StBoot;
         pc_q          <= RESET_PC;
         fetch_valid_q <= 1'b0;
         fetch_pc_q    <= RESET_PC;
         addr_err_q    <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= StFetch;
         pc_q          <= pc_d;
         // A fetch accepted in the same cycle as a redirect is on the wrong path.
         fetch_valid_q <= accept && !redirect;
         if (accept) begin
            fetch_pc_q <= pc_q;
         end
         if (redirect && rs_misaligned) begin
            addr_err_q <= 1'b1;
         end
         if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign Imem_req     = in_fetch && !Stall;
   assign Imem_addr    = pc_q;
   assign Fetch_valid  = fetch_valid_q;
   assign Fetch_pc     = fetch_pc_q;
   assign Fetch_pc4    = fetch_pc_q + 32'd4;
   assign Flush        = redirect;
   assign Addr_err     = addr_err_q;
   assign Redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Randomized and directed bench for pc_redirect_unit against a cycle-level reference model.
module tb_pc_redirect_unit;

   localparam logic [31:0] RstPc = 32'h0000_0100;
   localparam int unsigned CntW  = 2;
   localparam int unsigned CntMax = (1 << CntW) - 1;

   logic            clk;
   logic            rst_n;
   logic [1:0]      Jump_sel;
   logic [31:0]     Branch_pc4;
   logic [31:0]     Imm_sext;
   logic [25:0]     Target;
   logic [31:0]     RS;
   logic            Stall;
   logic            Imem_ready;
   logic            Imem_req;
   logic [31:0]     Imem_addr;
   logic            Fetch_valid;
   logic [31:0]     Fetch_pc;
   logic [31:0]     Fetch_pc4;
   logic            Flush;
   logic            Addr_err;
   logic [CntW-1:0] Redirect_cnt;

   pc_redirect_unit #(
      .RESET_PC (RstPc),
      .CNT_W    (CntW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Jump_sel     (Jump_sel),
      .Branch_pc4   (Branch_pc4),
      .Imm_sext     (Imm_sext),
      .Target       (Target),
      .RS           (RS),
      .Stall        (Stall),
      .Imem_ready   (Imem_ready),
      .Imem_req     (Imem_req),
      .Imem_addr    (Imem_addr),
      .Fetch_valid  (Fetch_valid),
      .Fetch_pc     (Fetch_pc),
      .Fetch_pc4    (Fetch_pc4),
      .Flush        (Flush),
      .Addr_err     (Addr_err),
      .Redirect_cnt (Redirect_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit          m_boot;
   bit [31:0]   m_pc;
   bit          m_fv;
   bit [31:0]   m_fpc;
   bit          m_err;
   int unsigned m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_boot = 1'b1;
      m_pc   = RstPc;
      m_fv   = 1'b0;
      m_fpc  = RstPc;
      m_err  = 1'b0;
      m_cnt  = 0;
   endtask

   function automatic bit [31:0] model_target(input bit [1:0] sel, input bit [31:0] bp4,
                                              input bit [31:0] imm, input bit [25:0] tgt,
                                              input bit [31:0] rs);
      bit [31:0] t;
      case (sel)
         2'd1:    t = bp4 + imm * 32'd4;
         2'd2:    t = (bp4 & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
         2'd3:    t = rs & 32'hFFFF_FFFC;
         default: t = bp4;
      endcase
      return t;
   endfunction

   task automatic check_all(input string tag, input bit redirect, input bit stall);
      check({tag, ".req"},   {31'd0, Imem_req},     {31'd0, !m_boot && !stall});
      check({tag, ".addr"},  Imem_addr,             m_pc);
      check({tag, ".flush"}, {31'd0, Flush},        {31'd0, redirect});
      check({tag, ".fv"},    {31'd0, Fetch_valid},  {31'd0, m_fv});
      check({tag, ".fpc"},   Fetch_pc,              m_fpc);
      check({tag, ".fpc4"},  Fetch_pc4,             m_fpc + 32'd4);
      check({tag, ".err"},   {31'd0, Addr_err},     {31'd0, m_err});
      check({tag, ".cnt"},   {30'd0, Redirect_cnt}, m_cnt);
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle(input string tag, input bit [1:0] sel, input bit [31:0] bp4,
                        input bit [31:0] imm, input bit [25:0] tgt, input bit [31:0] rs,
                        input bit stall, input bit ready);
      bit redirect;
      bit accept;
      Jump_sel   = sel;
      Branch_pc4 = bp4;
      Imm_sext   = imm;
      Target     = tgt;
      RS         = rs;
      Stall      = stall;
      Imem_ready = ready;
      redirect   = !m_boot && (sel != 2'd0);
      accept     = !m_boot && !stall && ready;
      #1;
      check_all(tag, redirect, stall);
      @(posedge clk);
      m_fv = accept && !redirect;
      if (accept) m_fpc = m_pc;
      if (redirect) begin
         if (sel == 2'd3 && rs[1:0] != 2'd0) m_err = 1'b1;
         if (m_cnt < CntMax) m_cnt++;
         m_pc = model_target(sel, bp4, imm, tgt, rs);
      end else if (accept) begin
         m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
      @(negedge clk);
   endtask

   task automatic seq(input string tag);
      cycle(tag, 2'd0, $urandom, $urandom, 26'($urandom), $urandom, 1'b0, 1'b1);
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         bit [1:0] sel;
         sel = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
         cycle("rnd", sel, $urandom, $urandom, 26'($urandom), $urandom,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      Jump_sel   = 2'd0;
      Branch_pc4 = '0;
      Imm_sext   = '0;
      Target     = '0;
      RS         = '0;
      Stall      = 1'b0;
      Imem_ready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_all("reset", 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Boot cycle, then sequential fetch from RESET_PC
      for (int i = 0; i < 4; i++) seq("seq");
      cycle("br01", 2'd1, 32'h0000_0200, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0, 1'b1);
      seq("after01");
      cycle("j10", 2'd2, 32'hA000_0010, 32'd0, 26'h0000040, 32'd0, 1'b0, 1'b1);
      seq("after10");
      cycle("jr11", 2'd3, 32'd0, 32'd0, 26'd0, 32'h0000_0403, 1'b0, 1'b1);
      seq("after11");
      cycle("br_more", 2'd1, 32'h0000_0404, 32'h0000_0004, 26'd0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle("stall", 2'd0, 32'd0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b1);
      cycle("jr_stall", 2'd3, 32'd0, 32'd0, 26'd0, 32'h0000_3000, 1'b1, 1'b1);
      cycle("stall2", 2'd0, 32'd0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b1);
      cycle("to_top", 2'd3, 32'd0, 32'd0, 26'd0, 32'hFFFF_FFFC, 1'b0, 1'b1);
      cycle("nrdy", 2'd0, 32'd0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
      cycle("wrap", 2'd0, 32'd0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b1);
      seq("wrapped");
      seq("wrapped2");

      rand_cycles(300);

      // Asynchronous reset in the middle of a cycle with a redirect pending
      Jump_sel = 2'd3;
      RS       = 32'h0000_1233;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst", 1'b0, Stall);
      @(negedge clk);
      rst_n = 1'b1;
      rand_cycles(300);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Consumer of the branch-resolution select (Jump_sel: 00 PC+4, 01 PC+4+SEXT(imm)<<2, 10 {PC[31:28],target,2'b0}, 11 RS).
- Owns the architectural fetch PC and drives the instruction-memory request handshake.
- Computes and applies redirect targets, and flushes the wrong-path fetch.
- Sits between execute-stage branch resolution and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- Jump_sel  in  2  redirect select from branch logic (encoding above)
- Branch_pc4  in  32  PC+4 of the resolving instruction
- Imm_sext  in  32  sign-extended 16-bit immediate (unshifted)
- Target  in  26  J-type target field
- RS  in  32  register value for JR/JALR
- Stall  in  1  hazard hold from decode; blocks fetch acceptance
- Imem_ready  in  1  instruction memory accepts request this cycle
- Imem_req  out  1  fetch request valid
- Imem_addr  out  32  fetch address (= PC register)
- Fetch_valid  out  1  registered; instruction returned this cycle is valid and on-path
- Fetch_pc  out  32  registered PC of the instruction marked by Fetch_valid
- Fetch_pc4  out  32  Fetch_pc + 4
- Flush  out  1  combinational; kill IF/ID contents this cycle
- Addr_err  out  1  sticky; a redirect target had bits [1:0] != 0
- Redirect_cnt  out  CNT_W  saturating count of applied redirects

Behaviour:
- Reset (rst_n=0, async):
  - PC=RESET_PC, state=BOOT.
  - Imem_req=0, Fetch_valid=0, Fetch_pc=RESET_PC.
  - Addr_err=0, Redirect_cnt=0.
- FSM states: BOOT, FETCH.
  - BOOT lasts exactly one cycle after reset release with Imem_req=0, then moves to FETCH unconditionally.
  - FETCH persists until reset. Reset mid-operation returns to BOOT; any in-flight fetch is discarded.
- In FETCH:
  - Imem_req = !Stall.
  - accept = Imem_req & Imem_ready.
- Target arithmetic (all mod 2^32, no overflow detection):
  - 01: Branch_pc4 + {Imm_sext[29:0],2'b00}
  - 10: {Branch_pc4[31:28],Target,2'b00}
  - 11: RS with bits [1:0] forced to 0. If RS[1:0] != 0, set Addr_err=1 (sticky until reset).
- redirect = (Jump_sel != 00) and state == FETCH. Jump_sel is ignored in BOOT.
- Next PC priority:
  - redirect → PC <= target.
  - else accept → PC <= PC+4 (wraps FFFF_FFFC→0000_0000).
  - else hold.
- Redirect overrides Stall and Imem_ready; no pending-redirect storage.
- Flush = redirect (same cycle, combinational).
- Fetch_valid on the next edge:
  - = accept & !redirect.
  - Fetch_pc <= PC when accept, else hold.
  - An accepted fetch coinciding with a redirect is wrong-path: Fetch_valid=0 next cycle.
- Stall with no redirect: PC, Fetch_pc hold; Fetch_valid=0 next cycle (bubble).
- Redirect latency: target on Imem_addr exactly one cycle after Jump_sel is sampled. The earliest on-path Fetch_valid is two cycles after.
- Redirect_cnt increments on each redirect and saturates at all-ones.
- Jump_sel=00 with redirect operands changing has no effect.

Test Plan:
- Reset, RESET_PC=0x100, Imem_ready=1 → BOOT cycle Imem_req=0. Then Imem_addr 0x100, 0x104, 0x108 on consecutive cycles; Fetch_valid=1 one cycle behind, with Fetch_pc matching.
- Jump_sel=01, Branch_pc4=0x200, Imm_sext=0xFFFF_FFFE → Flush=1 that cycle. Next Imem_addr=0x1F8; next-cycle Fetch_valid=0; Redirect_cnt=1.
- Jump_sel=10, Branch_pc4=0xA000_0010, Target=0x0000040 → Imem_addr=0xA000_0100. Jump_sel=11, RS=0x0000_0403 → Imem_addr=0x400, Addr_err=1 and held through later redirects.
- Stall=1 for 3 cycles, then Jump_sel=11 with Stall still 1 and RS=0x3000 → Imem_req=0 during stall; PC=0x3000 next cycle regardless; Fetch_valid stays 0.
- Imem_ready=0 with PC=0xFFFF_FFFC, then Imem_ready=1 → PC holds, then wraps to 0x0; Fetch_pc=0xFFFF_FFFC, Fetch_pc4=0x0.
- CNT_W=2, five redirects → Redirect_cnt 1,2,3,3,3. Assert rst_n=0 mid-stream asynchronously → all outputs return to reset values before the next clock edge.
